// File: rtl/zero_to_five_up_timer.sv
// MM:SS BCD up-counter for the irrigation timer: counts ticks from 00:00 up to a
// latched target and saturates at 59:59 when the target cannot be reached.
module zero_to_five_up_timer #(
    parameter int MAX_TENS  = 5,
    parameter int MAX_UNITS = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic [7:0] target_min,
    input  logic [7:0] target_sec,
    output logic [3:0] sec_units,
    output logic [3:0] sec_tens,
    output logic [3:0] min_units,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       done,
    output logic       finished
);

    localparam logic [3:0] TENS_TOP  = 4'(MAX_TENS);
    localparam logic [3:0] UNITS_TOP = 4'(MAX_UNITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [7:0] tgt_min;
    logic [7:0] tgt_sec;
    logic [7:0] tgt_min_next;
    logic [7:0] tgt_sec_next;

    logic [3:0] su_next;
    logic [3:0] st_next;
    logic [3:0] mu_next;
    logic [3:0] mt_next;
    logic       done_next;

    logic [3:0] su_inc;
    logic [3:0] st_inc;
    logic [3:0] mu_inc;
    logic [3:0] mt_inc;
    logic       carry_su;
    logic       carry_st;
    logic       carry_mu;
    logic       at_max;

    logic [7:0] cur_min;
    logic [7:0] cur_sec;
    logic [7:0] inc_min;
    logic [7:0] inc_sec;

    // Ripple BCD increment of the displayed count
    always_comb begin
        carry_su = (sec_units == UNITS_TOP);
        carry_st = carry_su && (sec_tens == TENS_TOP);
        carry_mu = carry_st && (min_units == UNITS_TOP);
        at_max   = carry_mu && (min_tens == TENS_TOP);

        su_inc = carry_su ? '0 : sec_units + 4'd1;
        st_inc = sec_tens;
        if (carry_su) begin
            st_inc = (sec_tens == TENS_TOP) ? '0 : sec_tens + 4'd1;
        end
        mu_inc = min_units;
        if (carry_st) begin
            mu_inc = (min_units == UNITS_TOP) ? '0 : min_units + 4'd1;
        end
        mt_inc = min_tens;
        if (carry_mu) begin
            mt_inc = (min_tens == TENS_TOP) ? '0 : min_tens + 4'd1;
        end
    end

    assign cur_min = {min_tens, min_units};
    assign cur_sec = {sec_tens, sec_units};
    assign inc_min = {mt_inc, mu_inc};
    assign inc_sec = {st_inc, su_inc};

    always_comb begin
        state_next   = state;
        tgt_min_next = tgt_min;
        tgt_sec_next = tgt_sec;
        su_next      = sec_units;
        st_next      = sec_tens;
        mu_next      = min_units;
        mt_next      = min_tens;
        done_next    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (clear) begin
                    su_next = '0;
                    st_next = '0;
                    mu_next = '0;
                    mt_next = '0;
                end else if (start) begin
                    state_next   = ST_RUN;
                    su_next      = '0;
                    st_next      = '0;
                    mu_next      = '0;
                    mt_next      = '0;
                    tgt_min_next = target_min;
                    tgt_sec_next = target_sec;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_next = ST_IDLE;
                    su_next    = '0;
                    st_next    = '0;
                    mu_next    = '0;
                    mt_next    = '0;
                end else if (stop) begin
                    state_next = ST_PAUSE;
                end else if (start) begin
                    state_next = ST_RUN;
                end else if (cur_min == tgt_min && cur_sec == tgt_sec) begin
                    // Only reachable with a 00:00 target; every other match exits on the tick
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                end else if (tick) begin
                    if (at_max) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end else begin
                        su_next = su_inc;
                        st_next = st_inc;
                        mu_next = mu_inc;
                        mt_next = mt_inc;
                        if (inc_min == tgt_min && inc_sec == tgt_sec) begin
                            state_next = ST_DONE;
                            done_next  = 1'b1;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (clear) begin
                    state_next = ST_IDLE;
                    su_next    = '0;
                    st_next    = '0;
                    mu_next    = '0;
                    mt_next    = '0;
                end else if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (clear) begin
                    state_next = ST_IDLE;
                    su_next    = '0;
                    st_next    = '0;
                    mu_next    = '0;
                    mt_next    = '0;
                end else if (start) begin
                    state_next   = ST_RUN;
                    su_next      = '0;
                    st_next      = '0;
                    mu_next      = '0;
                    mt_next      = '0;
                    tgt_min_next = target_min;
                    tgt_sec_next = target_sec;
                end
            end
            default: begin
                state_next = ST_IDLE;
                su_next    = '0;
                st_next    = '0;
                mu_next    = '0;
                mt_next    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            tgt_min   <= '0;
            tgt_sec   <= '0;
            sec_units <= '0;
            sec_tens  <= '0;
            min_units <= '0;
            min_tens  <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
            finished  <= 1'b0;
        end else begin
            state     <= state_next;
            tgt_min   <= tgt_min_next;
            tgt_sec   <= tgt_sec_next;
            sec_units <= su_next;
            sec_tens  <= st_next;
            min_units <= mu_next;
            min_tens  <= mt_next;
            running   <= (state_next == ST_RUN);
            done      <= done_next;
            finished  <= (state_next == ST_DONE);
        end
    end

endmodule
